imem_loadable: RTL
==================

# imem_loadable

Parametrised, loadable instruction memory for the MIPS fetch stage. It replaces fixed, compiled-in program ROMs. It gives the fetch stage a synchronous-read port with stall hold and address-window decode. A byte-stream loader port, typically fed by the UART bootloader, writes big-endian words into the array at runtime. While a load is in progress, the fetch port returns NOPs.

## Interface
Parameters:
- DATA_W, 32, instruction width; multiple of 8.
- ADDR_W, 30, word-address width (PC[31:2]).
- DEPTH, 1024, words in array; power of two.
- BASE, 0, first word address mapped to the array.
- LEN_W, 16, width of load length field.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  hold fetch output.
- addr  in  ADDR_W  fetch word address.
- inst  out  DATA_W  fetched instruction (registered).
- load_start  in  1  one-cycle request to begin a load.
- load_base  in  ADDR_W  first word address of load; sampled with load_start.
- load_len  in  LEN_W  number of words; sampled with load_start.
- byte_data  in  8  loader byte.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- load_busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse: load completed.
- load_err  out  1  one-cycle pulse: load request rejected.

## Operation
- Hit: BASE <= addr < BASE+DEPTH. The array index is addr-BASE, truncated to log2(DEPTH) bits.
- Fetch, each edge with stall=0:
  - If load_busy, inst <= 0.
  - Else if hit, inst <= mem[idx].
  - Else inst <= 0.
- Fetch with stall=1: inst holds its value. The stall effect has priority over load_busy; inst is not forced to 0 while stalled.
- Array contents are not reset; they are undefined until loaded.

Loader FSM states: IDLE, BYTES, WRITE, DONE.
- IDLE, on load_start:
  - load_len=0: pulse load_done next cycle (via DONE), no writes.
  - Range invalid (load_base outside window, or load_base+load_len-1 outside window, computed without overflow at ADDR_W+1 bits): pulse load_err next cycle, stay IDLE.
  - Otherwise: ptr <= load_base-BASE, rem <= load_len, bcnt <= 0, go to BYTES.
- BYTES: byte_ready=1.
  - On byte_valid: word <= {word[DATA_W-9:0], byte_data}, so the first byte lands in the MSBs (big-endian).
  - After the byte at bcnt = DATA_W/8-1, go to WRITE; otherwise bcnt++.
- WRITE: byte_ready=0. mem[ptr] <= word, ptr++, rem--, bcnt <= 0. Go to DONE if rem was 1, else BYTES.
- DONE: load_done=1 for exactly one cycle, then IDLE.
- load_busy=1 in BYTES, WRITE and DONE.
- load_start is ignored unless in IDLE.

## Timing
- Reset values: inst=0, byte_ready=0, load_busy=0, load_done=0, load_err=0, FSM=IDLE, ptr/rem/bcnt/word=0.
- Fetch latency: 1 cycle. addr presented in cycle N appears on inst after edge N+1.
- Load throughput: DATA_W/8+1 cycles per word with byte_valid held high. For DATA_W=32 this is 5 cycles/word.
- load_done asserts the cycle after the final WRITE. load_busy drops the cycle after that.
- load_err asserts the cycle after load_start; load_busy never rises for a rejected request.
- Fetch resumes returning array data on the first edge where load_busy=0 (first fetch after DONE).
- Reset mid-load:
  - FSM returns to IDLE immediately; the partial word is discarded.
  - Words already written are retained.
  - No load_done pulse.
- byte_valid outside BYTES is ignored; bytes are not consumed.

## Test plan
- Reset with rst=0, then release; fetch addr=5 → inst=0 throughout reset; no done/err pulses.
- Load: BASE=0, load_base=0, load_len=2, bytes 3C,1D,10,00,0C,00,14,03 back-to-back → load_done exactly 11 cycles after load_start. Fetch addr=0 → 3C1D1000; fetch addr=1 → 0C001403.
- During that load, fetch addr=0 every cycle → inst=0 while load_busy=1. Stall asserted before load_start → inst holds its prior value.
- load_base=DEPTH-1, load_len=2 → load_err pulse, load_busy stays 0. load_len=0 → load_done pulse, array unchanged.
- Fetch addr=DEPTH (out of window) → inst=0. Fetch with stall=1 while addr changes → inst unchanged; after stall drops, new data one cycle later.
- Assert rst mid-word during a 3-word load after word 0 is written → word 0 retained, word 1 location unchanged, FSM IDLE, byte_ready=0.

Source files
------------

// File: rtl/imem_loadable.sv
// imem_loadable: loadable instruction memory for the MIPS fetch stage.
// The fetch port is a registered, stallable read with address-window decode.
// A byte-stream loader assembles big-endian words and writes them into the array.
// The fetch port returns NOPs (zero) while a load is in progress.
module imem_loadable #(
   parameter int                DATA_W = 32,
   parameter int                ADDR_W = 30,
   parameter int                DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter int                LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] inst,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [LEN_W-1:0]  load_len,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err
);

   localparam int NB = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   // Wide enough that base + length never wraps, whichever field is wider.
   localparam int EW = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
   localparam logic [EW-1:0] WIN_LO = EW'(BASE);
   localparam logic [EW-1:0] WIN_SZ = EW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      BYTES,
      WRITE,
      DONE
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] inst_q;

   // Window offsets: an address below BASE wraps to a huge value, so a single
   // unsigned "< DEPTH" compare covers both ends of the window.
   logic [EW-1:0] fetchOff;
   logic [EW-1:0] reqOffBase;
   logic [EW-1:0] reqOffEnd;
   logic          fetchHit;
   logic          rangeOk;
   logic [IW-1:0] fetchIdx;

   assign fetchOff   = EW'(addr) - WIN_LO;
   assign fetchHit   = fetchOff < WIN_SZ;
   assign fetchIdx   = IW'(fetchOff);
   assign reqOffBase = EW'(load_base) - WIN_LO;
   assign reqOffEnd  = reqOffBase + EW'(load_len) - EW'(1);
   assign rangeOk    = (reqOffBase < WIN_SZ) && (reqOffEnd < WIN_SZ);

   assign byte_ready = (state_q == BYTES);
   assign load_busy  = (state_q != IDLE);
   assign load_done  = (state_q == DONE);
   assign load_err   = err_q;
   assign inst       = inst_q;

   // Loader state and datapath registers; a reset drops any partial word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   // Loader next-state: request decode, byte assembly, word write sequencing.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_start) begin
               if (load_len == '0) begin
                  state_d = DONE;
               end else if (!rangeOk) begin
                  err_d = 1'b1;
               end else begin
                  ptr_d   = IW'(reqOffBase);
                  rem_d   = load_len;
                  bcnt_d  = '0;
                  state_d = BYTES;
               end
            end
         end
         BYTES: begin
            if (byte_valid) begin
               word_d = (word_q << 8) | DATA_W'(byte_data);
               if (bcnt_q == BW'(NB - 1)) begin
                  state_d = WRITE;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         WRITE: begin
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            bcnt_d  = '0;
            state_d = (rem_q == LEN_W'(1)) ? DONE : BYTES;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Array write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (state_q == WRITE) begin
         mem[ptr_q] <= word_q;
      end
   end

   // Registered fetch: stall holds, an active load or a window miss reads as NOP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q <= '0;
      end else if (!stall) begin
         if (load_busy) begin
            inst_q <= '0;
         end else if (fetchHit) begin
            inst_q <= mem[fetchIdx];
         end else begin
            inst_q <= '0;
         end
      end
   end

endmodule
